// File: rtl/bus_src_fifo.sv
// First-word-fall-through packet FIFO feeding a bus arbiter. It has a circular buffer of any
// depth >= 2 and saturating overflow and underflow counters.
module bus_src_fifo #(
  parameter int pckg_sz   = 16,
  parameter int fifo_size = 8,
  parameter int cnt_w     = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           wr_en,
  input  logic [pckg_sz-1:0]             wr_data,
  input  logic                           pop,
  output logic [pckg_sz-1:0]             D_pop,
  output logic                           pndng,
  output logic                           full,
  output logic [$clog2(fifo_size+1)-1:0] count,
  output logic [cnt_w-1:0]               ovf_cnt,
  output logic [cnt_w-1:0]               unf_cnt
);

  // Handshake: the bus takes D_pop on any edge with pop=1 and pndng=1. pop with pndng=0
  // is an underflow and is counted. wr_en needs no ready signal. A write is accepted unless
  // the FIFO is full with no pop on the same edge; in that case the write is dropped and counted.

  localparam int ptr_w = $clog2(fifo_size);
  localparam int cw    = $clog2(fifo_size + 1);
  localparam logic [ptr_w-1:0] last_idx = ptr_w'(fifo_size - 1);
  localparam logic [cw-1:0]    depth    = cw'(fifo_size);

  logic [pckg_sz-1:0] mem [fifo_size];
  logic [ptr_w-1:0]   rd_ptr, wr_ptr;
  logic               do_wr, do_pop, ovf_hit, unf_hit;

  function automatic logic [ptr_w-1:0] next_ptr(input logic [ptr_w-1:0] p);
    return (p == last_idx) ? '0 : p + ptr_w'(1);
  endfunction

  assign pndng = (count != '0);
  assign full  = (count == depth);
  assign D_pop = pndng ? mem[rd_ptr] : '0;

  always_comb begin
    do_pop  = pop & pndng;
    // A full FIFO can take a write only when a pop frees the slot on the same edge.
    do_wr   = wr_en & (~full | pop);
    ovf_hit = wr_en & full & ~pop;
    unf_hit = pop & ~pndng;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      ovf_cnt <= '0;
      unf_cnt <= '0;
    end else begin
      if (do_wr)  wr_ptr <= next_ptr(wr_ptr);
      if (do_pop) rd_ptr <= next_ptr(rd_ptr);
      case ({do_wr, do_pop})
        2'b10:   count <= count + cw'(1);
        2'b01:   count <= count - cw'(1);
        default: count <= count;
      endcase
      if (ovf_hit && ovf_cnt != '1) ovf_cnt <= ovf_cnt + cnt_w'(1);
      if (unf_hit && unf_cnt != '1) unf_cnt <= unf_cnt + cnt_w'(1);
    end
  end

  // Storage has no reset; unread slots are hidden because D_pop is gated by pndng.
  always_ff @(posedge clk) begin
    if (!reset && do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: tb/tb_bus_src_fifo.sv
// Bench for bus_src_fifo: a directed vector table, hand-written corner sequences, and random
// traffic checked against a queue-based reference model.
module tb_bus_src_fifo;

  localparam int DEPTH = 8;
  localparam int MAXC  = 255;

  logic        clk, reset, wr_en, pop;
  logic [15:0] wr_data, D_pop;
  logic        pndng, full;
  logic [3:0]  count;
  logic [7:0]  ovf_cnt, unf_cnt;

  bus_src_fifo #(.pckg_sz(16), .fifo_size(DEPTH), .cnt_w(8)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .pop(pop),
    .D_pop(D_pop), .pndng(pndng), .full(full), .count(count),
    .ovf_cnt(ovf_cnt), .unf_cnt(unf_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst, we;
    logic [15:0] wd;
    logic        pop;
    int          cnt;
    logic        pnd, ful;
    logic [15:0] dp;
    int          ovf, unf;
  } vec_t;

  vec_t        tbl[$];
  logic [15:0] exp_q[$];
  int          m_ovf, m_unf;
  int          vec_cnt, err_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // reference model: packet queue and saturating counters
  task automatic model_step(input logic r, input logic w, input logic [15:0] d, input logic p);
    int n;
    if (r) begin
      exp_q.delete();
      m_ovf = 0;
      m_unf = 0;
    end else begin
      n = exp_q.size();
      if (p) begin
        if (n > 0) void'(exp_q.pop_front());
        else if (m_unf < MAXC) m_unf++;
      end
      if (w) begin
        if (n < DEPTH || p) exp_q.push_back(d);
        else if (m_ovf < MAXC) m_ovf++;
      end
    end
  endtask

  // driver
  task automatic drive(input logic r, input logic w, input logic [15:0] d, input logic p);
    reset = r; wr_en = w; wr_data = d; pop = p;
    @(posedge clk);
    #1;
    model_step(r, w, d, p);
    reset = 1'b0; wr_en = 1'b0; pop = 1'b0;
  endtask

  task automatic check_model(input string tag);
    int n;
    n = exp_q.size();
    chk({tag, ".count"}, 32'(count), 32'(n));
    chk({tag, ".pndng"}, 32'(pndng), 32'(n != 0));
    chk({tag, ".full"},  32'(full),  32'(n == DEPTH));
    chk({tag, ".D_pop"}, 32'(D_pop), (n != 0) ? 32'(exp_q[0]) : 32'h0);
    chk({tag, ".ovf"},   32'(ovf_cnt), 32'(m_ovf));
    chk({tag, ".unf"},   32'(unf_cnt), 32'(m_unf));
  endtask

  function automatic void add(input logic r, input logic w, input logic [15:0] d, input logic p,
                              input int c, input logic pn, input logic fu, input logic [15:0] dp,
                              input int o, input int u);
    vec_t v;
    v.rst = r; v.we = w; v.wd = d; v.pop = p; v.cnt = c;
    v.pnd = pn; v.ful = fu; v.dp = dp; v.ovf = o; v.unf = u;
    tbl.push_back(v);
  endfunction

  initial begin
    vec_cnt = 0; err_cnt = 0; m_ovf = 0; m_unf = 0;
    reset = 1'b1; wr_en = 1'b0; pop = 1'b0; wr_data = '0;

    // directed table: reset, single round trip, overflow, full write+pop, empty pop+write
    add(1, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0);
    add(0, 1, 16'h0201, 0, 1, 1, 0, 16'h0201, 0, 0);
    add(0, 0, 16'h0000, 1, 0, 0, 0, 16'h0000, 0, 0);
    for (int k = 0; k < 8; k++)
      add(0, 1, 16'(k), 0, k + 1, 1, (k == 7), 16'h0000, 0, 0);
    add(0, 1, 16'h0008, 0, 8, 1, 1, 16'h0000, 1, 0);
    for (int i = 0; i < 8; i++)
      add(0, 0, 16'h0000, 1, 7 - i, (i < 7), 0, (i < 7) ? 16'(i + 1) : 16'h0000, 1, 0);
    for (int k = 0; k < 8; k++)
      add(0, 1, 16'(16'h0010 + k), 0, k + 1, 1, (k == 7), 16'h0010, 1, 0);
    add(0, 1, 16'hFFAA, 1, 8, 1, 1, 16'h0011, 1, 0);
    for (int j = 1; j < 8; j++)
      add(0, 0, 16'h0000, 1, 8 - j, 1, 0, (j < 7) ? 16'(16'h0011 + j) : 16'hFFAA, 1, 0);
    add(0, 0, 16'h0000, 1, 0, 0, 0, 16'h0000, 1, 0);
    add(0, 1, 16'h0105, 1, 1, 1, 0, 16'h0105, 1, 1);
    add(0, 0, 16'h0000, 1, 0, 0, 0, 16'h0000, 1, 1);

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].we, tbl[i].wd, tbl[i].pop);
      chk($sformatf("tbl%0d.count", i), 32'(count),   32'(tbl[i].cnt));
      chk($sformatf("tbl%0d.pndng", i), 32'(pndng),   32'(tbl[i].pnd));
      chk($sformatf("tbl%0d.full", i),  32'(full),    32'(tbl[i].ful));
      chk($sformatf("tbl%0d.D_pop", i), 32'(D_pop),   32'(tbl[i].dp));
      chk($sformatf("tbl%0d.ovf", i),   32'(ovf_cnt), 32'(tbl[i].ovf));
      chk($sformatf("tbl%0d.unf", i),   32'(unf_cnt), 32'(tbl[i].unf));
    end

    // underflow counter saturation
    drive(1, 0, 16'h0000, 0);
    for (int i = 0; i < 300; i++) begin
      drive(0, 0, 16'h0000, 1);
      check_model("unf_run");
    end
    chk("unf_sat", 32'(unf_cnt), 32'd255);

    // reset mid-operation beats wr_en and pop, then pointers wrap past the last slot
    drive(1, 0, 16'h0000, 0);
    for (int k = 0; k < 5; k++) drive(0, 1, 16'(16'h0A00 + k), 0);
    check_model("preload");
    drive(1, 1, 16'hBEEF, 1);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_pndng", 32'(pndng), 32'd0);
    chk("rst_full",  32'(full),  32'd0);
    chk("rst_D_pop", 32'(D_pop), 32'd0);
    chk("rst_ovf",   32'(ovf_cnt), 32'd0);
    chk("rst_unf",   32'(unf_cnt), 32'd0);
    for (int k = 0; k < 12; k++) begin
      drive(0, 1, 16'(16'h0300 + k), 0);
      chk($sformatf("wrap%0d.D_pop", k), 32'(D_pop), 32'(16'h0300 + k));
      drive(0, 0, 16'h0000, 1);
      check_model($sformatf("wrap%0d", k));
    end

    // random traffic with phases biased toward full, empty and balanced
    drive(1, 0, 16'h0000, 0);
    for (int i = 0; i < 900; i++) begin
      int ph;
      logic r, w, p;
      logic [15:0] d;
      ph = (i / 100) % 3;
      r = ($urandom_range(0, 149) == 0);
      case (ph)
        0:       begin w = ($urandom_range(0, 9) < 8); p = ($urandom_range(0, 9) < 2); end
        1:       begin w = ($urandom_range(0, 9) < 2); p = ($urandom_range(0, 9) < 8); end
        default: begin w = $urandom_range(0, 1) != 0;  p = $urandom_range(0, 1) != 0;  end
      endcase
      d = 16'($urandom);
      if ($urandom_range(0, 7) == 0) d[15:8] = 8'hFF;
      drive(r, w, d, p);
      check_model($sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/bus_src_fifo.md
BUS_SRC_FIFO -- requirements
Module: bus_src_fifo

Interface
REQ-001 Parameter pckg_sz, default 16: packet width in bits; bits [pckg_sz-1:pckg_sz-8] carry the destination ID.
REQ-002 Parameter fifo_size, default 8: storage depth in packets, any integer >= 2.
REQ-003 Parameter cnt_w, default 8: width of each error counter.
REQ-004 The block SHALL use one clock, clk; reset is synchronous and active-high, named reset.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 wr_en  input  1  host write strobe; loads wr_data this edge.
REQ-008 wr_data  input  pckg_sz  packet from the host or agent.
REQ-009 pop  input  1  bus arbiter consumes the head packet this edge.
REQ-010 D_pop  output  pckg_sz  head packet presented to the bus.
REQ-011 pndng  output  1  FIFO holds at least one packet.
REQ-012 full  output  1  occupancy equals fifo_size.
REQ-013 count  output  $clog2(fifo_size+1)  current occupancy.
REQ-014 ovf_cnt  output  cnt_w  number of packets dropped on overflow.
REQ-015 unf_cnt  output  cnt_w  number of pops ignored on underflow.

Function
REQ-016 Storage SHALL be a circular buffer with read and write pointers that wrap from fifo_size-1 to 0; fifo_size need not be a power of two.
REQ-017 The FIFO SHALL be first-word-fall-through: D_pop equals the head entry whenever pndng=1, and D_pop SHALL be all-zero when pndng=0.
REQ-018 pndng SHALL equal (count != 0), and full SHALL equal (count == fifo_size); both are driven directly from registered count.
REQ-019 wr_en=1 with full=0 SHALL store wr_data at the write pointer and increment count at that edge; pndng rises the next cycle when the FIFO was empty.
REQ-020 pop=1 with pndng=1 SHALL advance the read pointer and decrement count; D_pop shows the next entry the following cycle.
REQ-021 wr_en=1 and pop=1 together with 0<count<fifo_size SHALL perform both operations, leaving count unchanged.
REQ-022 wr_en=1 and pop=1 together with full=1 SHALL accept the write and perform the pop; count stays fifo_size and no overflow is recorded.
REQ-023 wr_en=1 with full=1 and pop=0 SHALL drop wr_data, leave the contents unchanged, and increment ovf_cnt.
REQ-024 pop=1 with pndng=0 SHALL leave the contents unchanged and increment unf_cnt, including when wr_en=1 in the same cycle. In that case the write is accepted and there is no bypass.
REQ-025 ovf_cnt and unf_cnt SHALL saturate at 2**cnt_w-1 and never wrap.
REQ-026 Packet contents, including destination IDs such as broadcast 8'hFF, SHALL pass through unmodified and in order.
REQ-027 Write-to-bus latency SHALL be 1 cycle: data written at edge N is visible on D_pop from edge N onward when the FIFO was empty.

Reset
REQ-028 With reset=1 at a rising clk edge, the block SHALL clear the pointers, count, ovf_cnt and unf_cnt to 0. After that edge pndng=0, full=0 and D_pop=0.
REQ-029 reset SHALL take priority over wr_en and pop in the same cycle; neither operation takes effect and no counter increments.
REQ-030 Reset asserted mid-operation SHALL discard all stored packets; storage array contents need not be cleared.
REQ-031 Outputs SHALL be undefined-free (no X) from the first edge at which reset=1.

Verification
REQ-032 Reset, then write 16'h0201 -> next cycle: pndng=1, D_pop=16'h0201, count=1; then pop -> pndng=0, D_pop=0, count=0.
REQ-033 With fifo_size=8, write 9 packets 16'h0000..16'h0008 with no pops -> full=1, count=8, ovf_cnt=1; popping 8 times returns 0000..0007 in order.
REQ-034 Full FIFO, simultaneous wr_en (16'hFFAA) and pop -> count stays 8, ovf_cnt unchanged, and 16'hFFAA emerges 8th.
REQ-035 Empty FIFO, pop with wr_en=1 (16'h0105) -> unf_cnt=1, count=1, D_pop=16'h0105 next cycle.
REQ-036 Hold pop=1 on an empty FIFO for 300 cycles with cnt_w=8 -> unf_cnt saturates at 255.
REQ-037 Load 5 packets, assert reset with wr_en=1 and pop=1 -> after the edge count=0, pndng=0, ovf_cnt=0, unf_cnt=0; a subsequent write and read round-trips correctly, with the pointers wrapped past 7.
